// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync request/response path.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    FSYNC_RSP_DONE   = 2'd0,
    FSYNC_RSP_STORED = 2'd1,
    FSYNC_RSP_ERR    = 2'd2
  } fractal_sync_rsp_e;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP
  } fractal_sync_req_state_e;

endpackage

// File: rtl/fractal_sync_req_port_ctrl.sv
// Single-port request FSM: accept id, one-cycle RF check, hold typed response until consumed.
module fractal_sync_req_port_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ID_WIDTH-1:0] req_id_i,
  output logic [ID_WIDTH-1:0] rf_id_o,
  output logic                rf_check_o,
  input  logic                rf_present_i,
  input  logic                rf_id_err_i,
  input  logic                rf_bypass_i,
  input  logic                rf_ignore_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [1:0]          rsp_type_o,
  output logic [ID_WIDTH-1:0] rsp_id_o
);

  fractal_sync_req_state_e state_d, state_q;
  fractal_sync_rsp_e       type_d, type_q;
  logic [ID_WIDTH-1:0]     id_d, id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      type_q  <= FSYNC_RSP_DONE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    id_d        = id_q;
    req_ready_o = 1'b0;
    rf_check_o  = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          id_d    = req_id_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        rf_check_o = 1'b1;
        // RF verdict priority: id error, then same-cycle drop, then match, else stored
        if (rf_id_err_i) begin
          type_d  = FSYNC_RSP_ERR;
          state_d = RESP;
        end else if (rf_ignore_i) begin
          state_d = IDLE;
        end else if (rf_present_i || rf_bypass_i) begin
          type_d  = FSYNC_RSP_DONE;
          state_d = RESP;
        end else begin
          type_d  = FSYNC_RSP_STORED;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // id stays registered outside CHECK so the RF input does not toggle
  assign rf_id_o    = id_q;
  assign rsp_id_o   = id_q;
  assign rsp_type_o = type_q;

endmodule

// File: rtl/fractal_sync_1d_local_req_ctrl.sv
// Upstream request controller for the 1D local sync RF: N_PORTS independent port FSMs.
module fractal_sync_1d_local_req_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 1,
  parameter int unsigned N_PORTS  = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_PORTS-1:0]               req_valid_i,
  output logic [N_PORTS-1:0]               req_ready_o,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0] req_id_i,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0] rf_id_o,
  output logic [N_PORTS-1:0]               rf_check_o,
  input  logic [N_PORTS-1:0]               rf_present_i,
  input  logic [N_PORTS-1:0]               rf_id_err_i,
  input  logic [N_PORTS-1:0]               rf_bypass_i,
  input  logic [N_PORTS-1:0]               rf_ignore_i,
  output logic [N_PORTS-1:0]               rsp_valid_o,
  input  logic [N_PORTS-1:0]               rsp_ready_i,
  output logic [N_PORTS-1:0][1:0]          rsp_type_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0] rsp_id_o
);

  if (ID_WIDTH == 0) begin : gen_id_width_chk
    $error("ID_WIDTH must be greater than 0");
  end
  if (N_PORTS < 2) begin : gen_n_ports_chk
    $error("N_PORTS must be at least 2");
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : gen_port
    fractal_sync_req_port_ctrl #(
      .ID_WIDTH(ID_WIDTH)
    ) u_port_ctrl (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i[i]),
      .req_ready_o (req_ready_o[i]),
      .req_id_i    (req_id_i[i]),
      .rf_id_o     (rf_id_o[i]),
      .rf_check_o  (rf_check_o[i]),
      .rf_present_i(rf_present_i[i]),
      .rf_id_err_i (rf_id_err_i[i]),
      .rf_bypass_i (rf_bypass_i[i]),
      .rf_ignore_i (rf_ignore_i[i]),
      .rsp_valid_o (rsp_valid_o[i]),
      .rsp_ready_i (rsp_ready_i[i]),
      .rsp_type_o  (rsp_type_o[i]),
      .rsp_id_o    (rsp_id_o[i])
    );
  end

endmodule

// File: tb/tb_fractal_sync_1d_local_req_ctrl.sv
// Directed bench with a response scoreboard for fractal_sync_1d_local_req_ctrl.
module tb_fractal_sync_1d_local_req_ctrl;
  import fractal_sync_pkg::*;

  localparam int unsigned IdW = 6;
  localparam int unsigned Np  = 2;

  typedef struct packed {
    logic [1:0]     t;
    logic [IdW-1:0] id;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [Np-1:0]            req_valid, req_ready, rf_check, rf_present, rf_id_err;
  logic [Np-1:0]            rf_bypass, rf_ignore, rsp_valid, rsp_ready;
  logic [Np-1:0][IdW-1:0]   req_id, rf_id, rsp_id;
  logic [Np-1:0][1:0]       rsp_type;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  fractal_sync_1d_local_req_ctrl #(
    .ID_WIDTH(IdW),
    .N_PORTS (Np)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_id_i    (req_id),
    .rf_id_o     (rf_id),
    .rf_check_o  (rf_check),
    .rf_present_i(rf_present),
    .rf_id_err_i (rf_id_err),
    .rf_bypass_i (rf_bypass),
    .rf_ignore_i (rf_ignore),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_type_o  (rsp_type),
    .rsp_id_o    (rsp_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [1:0] t, input logic [IdW-1:0] id);
    exp_t e;
    e.t  = t;
    e.id = id;
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Pops an expectation on every completed response handshake
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int p = 0; p < Np; p++) begin
        if (!rst && rsp_valid[p] && rsp_ready[p]) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected p%0d: got type %0d id 0x%0h, expected no response",
                     p, rsp_type[p], rsp_id[p]);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rsp_type p%0d", p), int'(rsp_type[p]), int'(e.t));
            chk($sformatf("rsp_id p%0d", p), int'(rsp_id[p]), int'(e.id));
          end
        end
      end
    end
  endtask

  initial begin
    int hs_cnt;
    int chk_cnt;
    logic [IdW-1:0] nid;
    fork
      monitor();
    join_none

    rst = 1'b1;
    req_valid = '0;
    req_id = '0;
    rf_present = '0;
    rf_id_err = '0;
    rf_bypass = '0;
    rf_ignore = '0;
    rsp_ready = '1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset req_ready", int'(req_ready), 3);
    chk("reset rf_check", int'(rf_check), 0);
    chk("reset rf_id", int'(rf_id), 0);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_type0", int'(rsp_type[0]), int'(FSYNC_RSP_DONE));

    // Single request, RF all-zero -> STORED
    req_valid[0] = 1'b1;
    req_id[0] = 6'd4;
    push(0, FSYNC_RSP_STORED, 6'd4);
    tick();
    req_valid[0] = 1'b0;
    chk("t1 rf_check", int'(rf_check[0]), 1);
    chk("t1 rf_id", int'(rf_id[0]), 4);
    chk("t1 req_ready in check", int'(req_ready[0]), 0);
    tick();
    chk("t1 rsp_valid", int'(rsp_valid[0]), 1);
    chk("t1 rf_check low", int'(rf_check[0]), 0);
    tick();
    chk("t1 back idle", int'(req_ready[0]), 1);

    // Present during CHECK, consumer stalls; stray RF inputs in RESP must be ignored
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_id[0] = 6'd4;
    push(0, FSYNC_RSP_DONE, 6'd4);
    tick();
    req_valid[0] = 1'b0;
    req_id[0] = 6'd9;
    rf_present[0] = 1'b1;
    tick();
    rf_present[0] = 1'b0;
    rf_id_err[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2 hold valid", int'(rsp_valid[0]), 1);
      chk("t2 hold type", int'(rsp_type[0]), int'(FSYNC_RSP_DONE));
      chk("t2 hold id", int'(rsp_id[0]), 4);
      chk("t2 req_ready low", int'(req_ready[0]), 0);
      tick();
    end
    rf_id_err[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    chk("t2 idle ready", int'(req_ready[0]), 1);
    chk("t2 idle valid", int'(rsp_valid[0]), 0);

    // Same-cycle pair: bypass on port0, ignore on port1
    req_valid = 2'b11;
    req_id[0] = 6'd6;
    req_id[1] = 6'd6;
    push(0, FSYNC_RSP_DONE, 6'd6);
    tick();
    req_valid = 2'b00;
    chk("t3 both check", int'(rf_check), 3);
    rf_bypass[0] = 1'b1;
    rf_ignore[1] = 1'b1;
    tick();
    rf_bypass = '0;
    rf_ignore = '0;
    chk("t3 p0 rsp_valid", int'(rsp_valid[0]), 1);
    chk("t3 p1 no rsp", int'(rsp_valid[1]), 0);
    chk("t3 p1 ready", int'(req_ready[1]), 1);
    tick();

    // Error wins over present
    req_valid[1] = 1'b1;
    req_id[1] = 6'h3F;
    push(1, FSYNC_RSP_ERR, 6'h3F);
    tick();
    req_valid[1] = 1'b0;
    chk("t4 rf_id p1", int'(rf_id[1]), 'h3F);
    rf_id_err[1] = 1'b1;
    rf_present[1] = 1'b1;
    tick();
    rf_id_err = '0;
    rf_present = '0;
    chk("t4 rsp_valid p1", int'(rsp_valid[1]), 1);
    tick();

    // Reset while a response is held: discarded, nothing pushed
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_id[0] = 6'd5;
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("t5 held valid", int'(rsp_valid[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5 rsp_valid", int'(rsp_valid[0]), 0);
    chk("t5 req_ready", int'(req_ready[0]), 1);
    chk("t5 rf_id", int'(rf_id[0]), 0);
    chk("t5 rsp_id", int'(rsp_id[0]), 0);
    chk("t5 rsp_type", int'(rsp_type[0]), int'(FSYNC_RSP_DONE));
    rsp_ready[0] = 1'b1;
    tick();

    // Back-to-back with valid held high: one accept every 3 cycles
    hs_cnt = 0;
    chk_cnt = 0;
    nid = 6'd1;
    req_valid[0] = 1'b1;
    req_id[0] = nid;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("t6 ready c%0d", c), int'(req_ready[0]), (c % 3 == 0) ? 1 : 0);
      if (rf_check[0]) chk_cnt++;
      if (req_ready[0]) begin
        hs_cnt++;
        push(0, FSYNC_RSP_STORED, nid);
      end
      tick();
      if (req_ready[0] == 1'b0 && rf_check[0]) begin
        nid = nid + 6'd1;
        req_id[0] = nid;
      end
    end
    req_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rf_check[0]) chk_cnt++;
      tick();
    end
    chk("t6 accepts", hs_cnt, 3);
    chk("t6 check pulses", chk_cnt, 3);

    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_sync_1d_local_req_ctrl.md
Name: fractal_sync_1d_local_req_ctrl

Overview:
- Upstream request controller for the 1D local synchronization register file.
- Accepts synchronization requests from N_PORTS requesters over valid/ready handshakes and holds each request's barrier id.
- Issues a single-cycle check to the local RF, captures the RF verdict (present / id_err / bypass / ignore) and returns a typed response per port.
- Sits between the node's port interfaces and the local RF; also feeds the downstream wake/forward logic.

Parameters:
- ID_WIDTH, 1, width of a barrier id; must match the local RF.
- N_PORTS, 2, number of requester ports; must be >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- req_valid_i[N_PORTS]  in  1  request valid, per port.
- req_ready_o[N_PORTS]  out  1  request accepted, per port.
- req_id_i[N_PORTS]  in  ID_WIDTH  barrier id of the request.
- rf_id_o[N_PORTS]  out  ID_WIDTH  id driven to the RF.
- rf_check_o[N_PORTS]  out  1  RF check strobe.
- rf_present_i[N_PORTS]  in  1  RF: partner already recorded.
- rf_id_err_i[N_PORTS]  in  1  RF: invalid id.
- rf_bypass_i[N_PORTS]  in  1  RF: same-cycle pair, this port is the survivor.
- rf_ignore_i[N_PORTS]  in  1  RF: same-cycle pair, this port is dropped.
- rsp_valid_o[N_PORTS]  out  1  response valid.
- rsp_ready_i[N_PORTS]  in  1  response consumed.
- rsp_type_o[N_PORTS]  out  2  fractal_sync_rsp_e.
- rsp_id_o[N_PORTS]  out  ID_WIDTH  id of the responded request.

Behaviour:
- Ports are fully independent; one FSM per port with states IDLE, CHECK, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: register req_id_i into id_q and go to CHECK.
- CHECK:
  - Lasts exactly one cycle. rf_check_o=1, rf_id_o=id_q. req_ready_o=0.
  - The RF outputs are combinational; sample them at the end of this cycle and classify, in priority order:
    - id_err -> ERR
    - ignore -> DROP
    - present or bypass -> DONE
    - else -> STORED
  - DROP returns to IDLE with no response. Every other outcome registers type_q and goes to RESP.
- RESP:
  - rsp_valid_o=1, rsp_type_o=type_q, rsp_id_o=id_q.
  - Type, id and valid are held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
  - A new request is not accepted in the same cycle (req_ready_o=0 in RESP).
- Outside CHECK: rf_check_o=0 and rf_id_o=id_q. The id is kept stable to avoid RF toggling.
- Latency:
  - Request handshake in cycle n -> rf_check_o in cycle n+1 -> rsp_valid_o in cycle n+2.
  - Minimum request-to-request interval is 3 cycles with rsp_ready_i tied high.
  - A DROP port can accept again at n+2.
- Simultaneous events:
  - Two ports in CHECK with equal ids: the RF flags bypass on the lower index and ignore on the higher index. Responses are DONE on the lower port and none on the higher port.
  - rf_* inputs outside CHECK are don't-care and must not affect state.
- Reset (rst_i=1 at a clock edge, including mid-transaction):
  - All FSMs go to IDLE; id_q=0; type_q=DONE.
  - Outputs next cycle: req_ready_o=1, rf_check_o=0, rf_id_o=0, rsp_valid_o=0, rsp_type_o=DONE, rsp_id_o=0.
  - Any held response is discarded.
- req_id_i is sampled only on the handshake; later changes are ignored.
- Elaboration-time assertions: ID_WIDTH>0, N_PORTS>=2.

Decomposition:
- fractal_sync_pkg gains the enum fractal_sync_rsp_e (2 bits): FSYNC_RSP_DONE=0, FSYNC_RSP_STORED=1, FSYNC_RSP_ERR=2, value 3 reserved.
- fractal_sync_pkg also gains the FSM state enum fractal_sync_req_state_e: IDLE, CHECK, RESP.
- One sub-module, fractal_sync_req_port_ctrl, contains the single-port FSM plus id/type registers. The top module instantiates it N_PORTS times in a generate loop.

Test Plan:
- Reset then port0 req id=4, RF returns all-zero -> rf_check_o[0]=1 in cycle 1 with rf_id_o=4; rsp_valid_o[0]=1, type STORED, id 4 in cycle 2.
- Port0 req id=4 with rf_present_i=1 during CHECK, rsp_ready_i held 0 for 3 cycles -> rsp DONE/4 held stable 3 cycles; req_ready_o[0]=0 throughout; IDLE after handshake.
- Ports 0 and 1 both req id=6 in the same cycle, RF drives bypass[0]=1 and ignore[1]=1 -> port0 rsp DONE/6 at cycle 2; port1 no rsp_valid, req_ready_o[1]=1 at cycle 2.
- Port1 req id=0x3F with rf_id_err_i=1 and rf_present_i=1 -> rsp ERR (err wins over present).
- rst_i asserted in RESP with rsp_valid_o=1 -> next cycle rsp_valid_o=0, req_ready_o=1, rf_id_o=0.
- Back-to-back traffic on port0 with rsp_ready_i=1 and ids 1,2,3 -> accepts every 3 cycles; rsp ids 1,2,3 in order; rf_check_o pulses exactly once per request.
